// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and state encodings for the
// transmitter and the byte feeder that sits in front of it.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    // Feeder handshake sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } feeder_state_e;

    // Transmitter frame states (start bit, 8 data bits LSB first, stop bit).
    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_START_BIT = 2'd1,
        TX_DATA_BITS = 2'd2,
        TX_STOP_BIT  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart8_tx_feeder_if.sv
// System-side push/flush/status signals plus the transmitter handshake.
// master = system/transmitter side, slave = the feeder.
interface uart8_tx_feeder_if #(
    parameter int DEPTH = 16
) ();
    import uart_pkg::*;

    localparam int ADDR_W = $clog2(DEPTH);

    logic                   wr_en;
    logic [UART_DATA_W-1:0] wr_data;
    logic                   flush;
    logic                   full;
    logic                   empty;
    logic [ADDR_W:0]        level;
    logic                   overflow;
    logic                   tx_start;
    logic [UART_DATA_W-1:0] tx_data;
    logic                   tx_busy;
    logic                   tx_done;

    modport master (
        output wr_en, wr_data, flush, tx_busy, tx_done,
        input  full, empty, level, overflow, tx_start, tx_data
    );

    modport slave (
        input  wr_en, wr_data, flush, tx_busy, tx_done,
        output full, empty, level, overflow, tx_start, tx_data
    );

endinterface

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with registered full/empty/level.
// Pushes into a full FIFO are ignored; flush drops everything queued and
// wins over a same-cycle push or pop.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [UART_DATA_W-1:0] push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        level
);

    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]        level_q, level_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;
    logic                   do_push, do_pop;

    // Next pointer/level state; full/empty derived from the next level so they stay registered.
    always_comb begin
        do_push  = push && !full_q && !flush;
        do_pop   = pop && !empty_q && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
        full_d  = (level_d == LVL_FULL);
        empty_d = (level_d == '0);
    end

    // Pointer and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Byte storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    assign rd_data = mem[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = level_q;

endmodule

// File: rtl/uart8_tx_feeder.sv
// Byte-buffering front end for the 8-bit UART transmitter. Queues bytes in
// a FIFO and hands them one at a time to the transmitter's start/done/busy
// handshake. All outputs are registered.
module uart8_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    uart8_tx_feeder_if.slave      bus
);

    localparam int ADDR_W = $clog2(DEPTH);

    feeder_state_e          state_q, state_d;
    logic                   tx_start_q, tx_start_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic                   overflow_q, overflow_d;
    logic                   pop;
    logic [UART_DATA_W-1:0] fifo_rd_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [ADDR_W:0]        fifo_level;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.wr_en),
        .push_data (bus.wr_data),
        .pop       (pop),
        .flush     (bus.flush),
        .rd_data   (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Handshake sequencing: pop and launch a byte only when the transmitter is idle,
    // then hold off until it reports done. A done outside WAIT is meaningless and dropped.
    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = '0;
        pop        = 1'b0;
        // A push refused for lack of room; a flush-killed push is not an overflow.
        overflow_d = bus.wr_en && fifo_full && !bus.flush;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !bus.tx_busy) begin
                    state_d    = ISSUE;
                    tx_start_d = 1'b1;
                    tx_data_d  = fifo_rd_data;
                    pop        = 1'b1;
                end
            end
            ISSUE:   state_d = WAIT;
            WAIT:    if (bus.tx_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state and registered handshake/overflow outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.level    = fifo_level;
    assign bus.overflow = overflow_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart8_tx_feeder.sv
// Directed bench for uart8_tx_feeder (DEPTH=4) with a behavioural transmitter:
// start sampled at S, busy for 9 clocks, done pulse and busy drop at S+9.
module tb_uart8_tx_feeder;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       hold_busy = 1'b0;
    logic       m_busy    = 1'b0;
    logic       m_done    = 1'b0;
    int         m_cnt     = 0;
    int         cyc       = 0;
    int         n_cmp     = 0;
    int         n_bad     = 0;
    int         sidx      = 0;
    logic [7:0] sent_q[$];
    int         start_cyc[$];

    uart8_tx_feeder_if #(.DEPTH(DEPTH)) bus ();

    uart8_tx_feeder #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.tx_busy = m_busy | hold_busy;
    assign bus.tx_done = m_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model; it has no reset, like the real one.
    always @(posedge clk) begin
        m_done <= 1'b0;
        if (!m_busy) begin
            if (bus.tx_start) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                sent_q.push_back(bus.tx_data);
                start_cyc.push_back(cyc);
            end
        end else if (m_cnt == 8) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_sent(input string tag, input logic [7:0] exp);
        logic [31:0] obs;
        obs = 32'hFFFF_FFFF;
        if (sidx < sent_q.size()) obs = 32'(sent_q[sidx]);
        sidx++;
        check(tag, obs, 32'(exp));
    endtask

    initial begin
        int k;
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.flush   = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_full",     32'(bus.full),     32'd0);
        check("rst_empty",    32'(bus.empty),    32'd1);
        check("rst_level",    32'(bus.level),    32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("rst_tx_data",  32'(bus.tx_data),  32'h00);
        @(negedge clk) rst = 1'b0;
        tick();

        // single byte: push at E0, start high E1..E2
        bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
        tick();
        bus.wr_en = 1'b0;
        check("single_empty_e0",  32'(bus.empty),    32'd0);
        check("single_level_e0",  32'(bus.level),    32'd1);
        check("single_start_e0",  32'(bus.tx_start), 32'd0);
        tick();
        check("single_start_e1",  32'(bus.tx_start), 32'd1);
        check("single_data_e1",   32'(bus.tx_data),  32'hA5);
        check("single_level_e1",  32'(bus.level),    32'd0);
        check("single_empty_e1",  32'(bus.empty),    32'd1);
        tick();
        check("single_start_e2",  32'(bus.tx_start), 32'd0);
        check("single_data_e2",   32'(bus.tx_data),  32'h00);
        repeat (12) tick();
        check_sent("single_sent", 8'hA5);

        // burst 01..04: pops overlap pushes, frames 12 clk apart
        for (int i = 1; i <= 4; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(i);
            tick();
        end
        bus.wr_en = 1'b0;
        check("burst_level", 32'(bus.level), 32'd3);
        check("burst_full",  32'(bus.full),  32'd0);
        repeat (60) tick();
        for (int i = 1; i <= 4; i++) check_sent($sformatf("burst_sent%0d", i), 8'(i));
        if (start_cyc.size() >= 5) begin
            for (int i = 2; i <= 4; i++)
                check($sformatf("burst_gap%0d", i), 32'(start_cyc[i] - start_cyc[i-1]), 32'd12);
        end else begin
            check("burst_starts", 32'(start_cyc.size()), 32'd5);
        end
        check("burst_level_end", 32'(bus.level), 32'd0);
        check("burst_empty_end", 32'(bus.empty), 32'd1);

        // overflow: transmitter held busy, 5 pushes into DEPTH=4
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'h10 + 8'(i);
            tick();
            if (i == 3) begin
                check("ovf_full4", 32'(bus.full),     32'd1);
                check("ovf_none4", 32'(bus.overflow), 32'd0);
            end
        end
        bus.wr_en = 1'b0;
        check("ovf_pulse",  32'(bus.overflow), 32'd1);
        check("ovf_level",  32'(bus.level),    32'd4);
        tick();
        check("ovf_clear",  32'(bus.overflow), 32'd0);
        hold_busy = 1'b0;
        tick();
        check("ovf_start",  32'(bus.tx_start), 32'd1);
        check("ovf_data",   32'(bus.tx_data),  32'h10);
        check("ovf_level3", 32'(bus.level),    32'd3);
        check("ovf_full0",  32'(bus.full),     32'd0);
        repeat (60) tick();
        for (int i = 0; i < 4; i++) check_sent($sformatf("ovf_sent%0d", i), 8'h10 + 8'(i));
        check("ovf_empty_end", 32'(bus.empty), 32'd1);

        // flush while waiting on C3; same-cycle push of 77 dropped silently
        bus.wr_en = 1'b1; bus.wr_data = 8'hC3;
        tick();
        bus.wr_data = 8'h3C;
        tick();
        bus.wr_en = 1'b0;
        check("fl_start", 32'(bus.tx_start), 32'd1);
        check("fl_data",  32'(bus.tx_data),  32'hC3);
        check("fl_level", 32'(bus.level),    32'd1);
        tick();
        bus.flush = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h77;
        tick();
        bus.flush = 1'b0; bus.wr_en = 1'b0;
        check("fl_level0", 32'(bus.level),    32'd0);
        check("fl_empty",  32'(bus.empty),    32'd1);
        check("fl_novf",   32'(bus.overflow), 32'd0);
        repeat (30) tick();
        check_sent("fl_sent", 8'hC3);
        check("fl_level_end", 32'(bus.level), 32'd0);

        // reset mid-frame, then busy gating and stray done in IDLE
        bus.wr_en = 1'b1; bus.wr_data = 8'h5A;
        tick();
        bus.wr_data = 8'h66;
        tick();
        bus.wr_en = 1'b0;
        repeat (3) tick();
        check("prerst_level", 32'(bus.level), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_level",    32'(bus.level),    32'd0);
        check("arst_empty",    32'(bus.empty),    32'd1);
        check("arst_full",     32'(bus.full),     32'd0);
        check("arst_tx_start", 32'(bus.tx_start), 32'd0);
        check("arst_tx_data",  32'(bus.tx_data),  32'h00);
        check("arst_overflow", 32'(bus.overflow), 32'd0);
        @(negedge clk) rst = 1'b0;
        tick();
        bus.wr_en = 1'b1; bus.wr_data = 8'h99;
        tick();
        bus.wr_en = 1'b0;
        check("rst_push_level", 32'(bus.level),    32'd1);
        check("rst_push_start", 32'(bus.tx_start), 32'd0);
        k = 0;
        while (k < 20 && bus.tx_start !== 1'b1) begin
            tick();
            k++;
        end
        check("rst_busy_gate", 32'(k), 32'd6);
        check("rst_start_data", 32'(bus.tx_data), 32'h99);
        repeat (20) tick();
        check_sent("rst_sent_old", 8'h5A);
        check_sent("rst_sent_new", 8'h99);

        // wrap-around: 10 bytes interleaved with pops, pointers wrap twice
        for (int i = 0; i < 10; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'h20 + 8'(i);
            tick();
            bus.wr_en = 1'b0;
            check($sformatf("wrap_novf%0d", i), 32'(bus.overflow), 32'd0);
            repeat (8) tick();
        end
        repeat (60) tick();
        for (int i = 0; i < 10; i++) check_sent($sformatf("wrap_sent%0d", i), 8'h20 + 8'(i));
        check("wrap_level", 32'(bus.level), 32'd0);
        check("wrap_empty", 32'(bus.empty), 32'd1);
        check("sent_total", 32'(sent_q.size()), 32'd22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
